// File: rtl/an_tx_pkg.sv
// Shared types and constants for the AN_TX balance sequencer.
package an_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DWELL
    } state_t;

    localparam int C_TBL_DEPTH = 8;
    localparam int C_BAL_W     = 6;
    localparam int C_DWELL_W   = 16;

    // Ceiling log2 with a floor of one bit.
    function automatic int f_log2(input int v);
        int n;
        n = 1;
        while ((1 << n) < v)
            n++;
        return n;
    endfunction

endpackage

// File: rtl/an_tx_psw_deb.sv
// Push-switch synchroniser and tick-based debouncer.
// Emits a one-cycle pulse on each debounced 0->1 transition.
module an_tx_psw_deb
    import an_tx_pkg::*;
#(
    parameter int C_DEB_TICKs = 16
) (
    input  logic CK_i,
    input  logic RST_i,
    input  logic TICK_i,
    input  logic PSW_i,
    output logic PRESS_o
);

    localparam int C_CW = f_log2(C_DEB_TICKs + 1);
    localparam logic [C_CW-1:0] C_CNT_LAST = C_CW'(C_DEB_TICKs - 1);

    logic            r_s1;
    logic            r_s2;
    logic            r_stable;
    logic            r_press;
    logic [C_CW-1:0] r_cnt;
    logic            w_diff;
    logic            w_flip;

    assign w_diff = r_s2 ^ r_stable;
    assign w_flip = w_diff & TICK_i & (r_cnt == C_CNT_LAST);

    always_ff @(posedge CK_i) begin
        if (RST_i) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_stable <= 1'b0;
            r_press  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_s1    <= PSW_i;
            r_s2    <= r_s1;
            r_press <= w_flip & r_s2;
            // Any return to the settled level restarts the count.
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (w_flip) begin
                r_stable <= r_s2;
                r_cnt    <= '0;
            end else if (TICK_i) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign PRESS_o = r_press;

endmodule

// File: rtl/an_tx_balance_seq.sv
// Table-driven sequencer for the AN_TX BUS_BALANCEs input.
// Plays {balance, dwell} entries once or looped, with manual override.
module an_tx_balance_seq
    import an_tx_pkg::*;
#(
    parameter int          C_CK_Fs         = 135_000_000,
    parameter int          C_TICK_Fs       = 1_000,
    parameter int          C_SIM_TICK_CKNs = 0,
    parameter int          C_DEB_TICKs     = 16,
    parameter logic [5:0]  C_IDLE_BAL      = 6'h3F
) (
    input  logic        CK_i,
    input  logic        RST_i,
    input  logic        WR_i,
    input  logic [2:0]  WR_ADRs_i,
    input  logic [5:0]  WR_BALs_i,
    input  logic [15:0] WR_DWELLs_i,
    input  logic [2:0]  LAST_IDXs_i,
    input  logic        LOOP_i,
    input  logic        RUN_i,
    input  logic        PSW_i,
    input  logic        MAN_i,
    input  logic [5:0]  MAN_BALs_i,
    output logic [5:0]  BUS_BALANCEs_o,
    output logic        BUSY_o,
    output logic [2:0]  IDXs_o,
    output logic        STEP_o,
    output logic        DONE_o
);

    localparam int C_N = (C_SIM_TICK_CKNs > 0) ? C_SIM_TICK_CKNs
                                               : C_CK_Fs / C_TICK_Fs;
    localparam int C_PRE_W = f_log2(C_N);
    localparam logic [C_PRE_W-1:0] C_PRE_MAX = C_PRE_W'(C_N - 1);
    // The LOAD cycle itself is the first clock of the dwell.
    localparam logic [C_PRE_W-1:0] C_PRE_LD  = (C_N > 1) ? C_PRE_W'(1) : '0;

    state_t                       r_state;
    state_t                       w_nxt;
    logic [C_PRE_W-1:0]           r_pre;
    logic [C_DWELL_W-1:0]         r_dcnt;
    logic [2:0]                   r_idx;
    logic [2:0]                   r_last;
    logic [C_BAL_W-1:0]           r_seq;
    logic [C_BAL_W-1:0]           r_out;
    logic                         r_run_d;
    logic [C_BAL_W+C_DWELL_W-1:0] r_tbl [C_TBL_DEPTH];

    logic                 w_tick;
    logic                 w_press;
    logic                 w_idle;
    logic                 w_start;
    logic                 w_abort;
    logic                 w_expire;
    logic                 w_is_last;
    logic [C_BAL_W-1:0]   w_rd_bal;
    logic [C_DWELL_W-1:0] w_rd_dw;
    logic [C_BAL_W-1:0]   w_seq;
    logic                 w_busy;
    logic                 w_step;
    logic                 w_done;

    an_tx_psw_deb #(
        .C_DEB_TICKs (C_DEB_TICKs)
    ) u_deb (
        .CK_i    (CK_i),
        .RST_i   (RST_i),
        .TICK_i  (w_tick),
        .PSW_i   (PSW_i),
        .PRESS_o (w_press)
    );

    always_ff @(posedge CK_i) begin
        if (WR_i)
            r_tbl[WR_ADRs_i] <= {WR_BALs_i, WR_DWELLs_i};
    end

    assign {w_rd_bal, w_rd_dw} = r_tbl[r_idx];

    assign w_tick    = (r_pre == C_PRE_MAX);
    assign w_idle    = (r_state == IDLE);
    assign w_start   = (( RUN_i & ~r_run_d) | w_press) &  w_idle;
    assign w_abort   = ((~RUN_i &  r_run_d) | w_press) & ~w_idle;
    assign w_expire  = (r_state == DWELL) & w_tick & (r_dcnt == 16'd1);
    assign w_is_last = (r_idx == r_last);

    always_ff @(posedge CK_i) begin
        if (RST_i)
            r_state <= IDLE;
        else
            r_state <= w_nxt;
    end

    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_start)
                    w_nxt = LOAD;
            end
            LOAD: begin
                w_nxt = w_abort ? IDLE : DWELL;
            end
            DWELL: begin
                if (w_abort)
                    w_nxt = IDLE;
                else if (w_expire)
                    w_nxt = (!w_is_last || LOOP_i) ? LOAD : IDLE;
            end
            default: w_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state != IDLE);
        w_step = (r_state == LOAD);
        w_done = w_expire & ~w_abort & w_is_last & ~LOOP_i;
    end

    always_ff @(posedge CK_i) begin
        if (RST_i) begin
            r_pre   <= '0;
            r_dcnt  <= '0;
            r_idx   <= '0;
            r_last  <= '0;
            r_seq   <= C_IDLE_BAL;
            r_run_d <= 1'b0;
        end else begin
            r_run_d <= RUN_i;
            if (r_state == LOAD)
                r_pre <= C_PRE_LD;
            else if (w_tick)
                r_pre <= '0;
            else
                r_pre <= r_pre + 1'b1;
            if (w_start) begin
                r_idx  <= 3'd0;
                r_last <= LAST_IDXs_i;
            end
            if (r_state == LOAD) begin
                r_dcnt <= (w_rd_dw == '0) ? 16'd1 : w_rd_dw;
                r_seq  <= w_rd_bal;
            end else if (r_state == DWELL && !w_abort) begin
                if (w_tick)
                    r_dcnt <= r_dcnt - 16'd1;
                if (w_expire && (!w_is_last || LOOP_i))
                    r_idx <= w_is_last ? 3'd0 : r_idx + 3'd1;
            end
        end
    end

    always_comb begin
        w_seq = r_seq;
        if (r_state == LOAD)
            w_seq = w_rd_bal;
        else if (r_state == IDLE)
            w_seq = C_IDLE_BAL;
    end

    always_ff @(posedge CK_i) begin
        if (RST_i)
            r_out <= C_IDLE_BAL;
        else
            r_out <= MAN_i ? MAN_BALs_i : w_seq;
    end

    assign BUS_BALANCEs_o = r_out;
    assign BUSY_o         = w_busy;
    assign IDXs_o         = r_idx;
    assign STEP_o         = w_step;
    assign DONE_o         = w_done;

endmodule

// File: tb/tb_an_tx_balance_seq.sv
// Self-checking bench for an_tx_balance_seq (tick = 4 clocks, debounce = 2 ticks).
// Expected per-cycle behaviour comes from an entry-schedule model.
module tb_an_tx_balance_seq;

    localparam int NMAX = 128;
    localparam int NCK  = 4;
    localparam int NOAB = 1000;

    logic        CK = 1'b0;
    logic        RST_i = 1'b1;
    logic        WR_i = 1'b0;
    logic [2:0]  WR_ADRs_i = '0;
    logic [5:0]  WR_BALs_i = '0;
    logic [15:0] WR_DWELLs_i = '0;
    logic [2:0]  LAST_IDXs_i = '0;
    logic        LOOP_i = 1'b0;
    logic        RUN_i = 1'b0;
    logic        PSW_i = 1'b0;
    logic        MAN_i = 1'b0;
    logic [5:0]  MAN_BALs_i = '0;
    logic [5:0]  BUS_BALANCEs_o;
    logic        BUSY_o;
    logic [2:0]  IDXs_o;
    logic        STEP_o;
    logic        DONE_o;

    int total = 0;
    int bad = 0;
    int g_t = 0;

    logic [5:0] m_bal [8];
    int         m_dw  [8];
    int e_out  [NMAX];
    int e_busy [NMAX];
    int e_step [NMAX];
    int e_done [NMAX];
    int e_idx  [NMAX];

    an_tx_balance_seq #(
        .C_SIM_TICK_CKNs (NCK),
        .C_DEB_TICKs     (2)
    ) dut (
        .CK_i           (CK),
        .RST_i          (RST_i),
        .WR_i           (WR_i),
        .WR_ADRs_i      (WR_ADRs_i),
        .WR_BALs_i      (WR_BALs_i),
        .WR_DWELLs_i    (WR_DWELLs_i),
        .LAST_IDXs_i    (LAST_IDXs_i),
        .LOOP_i         (LOOP_i),
        .RUN_i          (RUN_i),
        .PSW_i          (PSW_i),
        .MAN_i          (MAN_i),
        .MAN_BALs_i     (MAN_BALs_i),
        .BUS_BALANCEs_o (BUS_BALANCEs_o),
        .BUSY_o         (BUSY_o),
        .IDXs_o         (IDXs_o),
        .STEP_o         (STEP_o),
        .DONE_o         (DONE_o)
    );

    always #5 CK = ~CK;

    initial begin
        #500000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic step;
        @(posedge CK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s t=%0d obs=%0h exp=%0h", tag, g_t, obs, exp);
        end
    endtask

    task automatic wr_entry(input int a, input logic [5:0] b, input int d);
        WR_i = 1'b1;
        WR_ADRs_i = 3'(a);
        WR_BALs_i = b;
        WR_DWELLs_i = 16'(d);
        step();
        WR_i = 1'b0;
        m_bal[a] = b;
        m_dw[a] = d;
    endtask

    // Cycle 0 carries the RUN_i rise; cycle ab is the first idle cycle
    // after an abort (RUN_i falls in cycle ab-1).
    task automatic run_seq(input int last, input bit loop, input int nst,
                           input int ab, input int wat, input int wadr,
                           input logic [5:0] wbal, input int wdw,
                           input int mf, input int mt,
                           input logic [5:0] mbal);
        int s, e, d, dur;
        logic [5:0] b;
        for (int t = 0; t < NMAX; t++) begin
            e_out[t] = 'h3F;
            e_busy[t] = 0;
            e_step[t] = 0;
            e_done[t] = 0;
            e_idx[t] = 0;
        end
        s = 1;
        e = 0;
        while (s < ab && s <= nst) begin
            if (wat >= 0 && wat < s && wadr == e) begin
                b = wbal;
                d = wdw;
            end else begin
                b = m_bal[e];
                d = m_dw[e];
            end
            dur = ((d == 0) ? 1 : d) * NCK;
            e_step[s] = 1;
            for (int t = s; t < s + dur && t < NMAX; t++)
                if (t < ab) begin
                    e_busy[t] = 1;
                    e_idx[t] = e;
                end
            for (int t = s + 1; t <= s + dur && t < NMAX; t++)
                e_out[t] = int'(b);
            if (e == last) begin
                if (!loop) begin
                    if (s + dur - 1 < ab - 1 && s + dur - 1 < NMAX)
                        e_done[s + dur - 1] = 1;
                    break;
                end
                e = 0;
            end else begin
                e++;
            end
            s += dur;
        end
        for (int t = 1; t < NMAX; t++) begin
            if (t > ab)
                e_out[t] = 'h3F;
            if (mf >= 0 && t - 1 >= mf && t - 1 < mt)
                e_out[t] = int'(mbal);
        end
        LOOP_i = loop;
        LAST_IDXs_i = 3'(last);
        for (int t = 0; t <= nst; t++) begin
            g_t = t;
            if (t > 0) begin
                chk("out", 16'(BUS_BALANCEs_o), 16'(e_out[t]));
                chk("busy", 16'(BUSY_o), 16'(e_busy[t]));
                chk("step", 16'(STEP_o), 16'(e_step[t]));
                chk("done", 16'(DONE_o), 16'(e_done[t]));
                if (e_busy[t] != 0)
                    chk("idx", 16'(IDXs_o), 16'(e_idx[t]));
            end
            RUN_i = (t < ab - 1);
            WR_i = (t == wat);
            WR_ADRs_i = 3'(wadr);
            WR_BALs_i = wbal;
            WR_DWELLs_i = 16'(wdw);
            MAN_i = (mf >= 0 && t >= mf && t < mt);
            MAN_BALs_i = mbal;
            step();
        end
        WR_i = 1'b0;
        MAN_i = 1'b0;
        RUN_i = 1'b0;
        repeat (3) step();
        chk("idle_after", 16'(BUSY_o), 16'd0);
        if (wat >= 0 && wat <= nst) begin
            m_bal[wadr] = wbal;
            m_dw[wadr] = wdw;
        end
    endtask

    task automatic wait_busy(input logic lvl, input string tag);
        int n;
        n = 0;
        while (BUSY_o !== lvl && n < 60) begin
            step();
            n++;
        end
        chk(tag, 16'(BUSY_o), 16'(lvl));
    endtask

    initial begin
        int last, ab, nst, wat, mf;
        bit lp;
        for (int i = 0; i < 8; i++) begin
            m_bal[i] = 6'h3F;
            m_dw[i] = 1;
        end
        RST_i = 1'b1;
        repeat (3) step();
        chk("rst_out", 16'(BUS_BALANCEs_o), 16'h3F);
        chk("rst_busy", 16'(BUSY_o), 16'd0);
        chk("rst_idx", 16'(IDXs_o), 16'd0);
        chk("rst_step", 16'(STEP_o), 16'd0);
        chk("rst_done", 16'(DONE_o), 16'd0);
        RST_i = 1'b0;
        step();
        chk("post_rst_out", 16'(BUS_BALANCEs_o), 16'h3F);

        wr_entry(0, 6'h05, 2);
        wr_entry(1, 6'h2A, 1);
        step();
        run_seq(1, 1'b0, 20, NOAB, -1, 0, 6'h00, 0, -1, -1, 6'h00);
        run_seq(1, 1'b1, 32, 28, -1, 0, 6'h00, 0, -1, -1, 6'h00);

        wr_entry(0, 6'h07, 0);
        step();
        run_seq(1, 1'b0, 14, NOAB, -1, 0, 6'h00, 0, -1, -1, 6'h00);

        wr_entry(0, 6'h05, 2);
        step();
        run_seq(1, 1'b0, 16, NOAB, 3, 1, 6'h11, 1, -1, -1, 6'h00);
        run_seq(1, 1'b0, 16, NOAB, 1, 0, 6'h22, 3, -1, -1, 6'h00);
        run_seq(1, 1'b0, 24, NOAB, -1, 0, 6'h00, 0, -1, -1, 6'h00);

        run_seq(1, 1'b1, 40, 36, -1, 0, 6'h00, 0, 10, 20, 6'h0C);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 8; i++)
                wr_entry(i, 6'($urandom_range(0, 63)), $urandom_range(0, 3));
            step();
            last = $urandom_range(0, 7);
            lp = 1'($urandom_range(0, 1));
            if (lp) begin
                ab = $urandom_range(5, 90);
                nst = ab + 3;
            end else begin
                ab = NOAB;
                nst = 110;
            end
            wat = $urandom_range(1, 30);
            mf = $urandom_range(2, 40);
            run_seq(last, lp, nst, ab, wat, $urandom_range(0, 7),
                    6'($urandom_range(0, 63)), $urandom_range(0, 3),
                    mf, mf + $urandom_range(1, 10),
                    6'($urandom_range(0, 63)));
        end

        wr_entry(0, 6'h05, 2);
        wr_entry(1, 6'h2A, 1);
        LAST_IDXs_i = 3'd1;
        LOOP_i = 1'b1;
        g_t = -1;
        repeat (3) begin
            PSW_i = 1'b1;
            repeat (3) step();
            PSW_i = 1'b0;
            repeat (5) step();
        end
        repeat (30) step();
        chk("psw_bounce", 16'(BUSY_o), 16'd0);
        PSW_i = 1'b1;
        wait_busy(1'b1, "psw_start");
        repeat (20) step();
        PSW_i = 1'b0;
        repeat (30) step();
        chk("psw_release", 16'(BUSY_o), 16'd1);
        PSW_i = 1'b1;
        wait_busy(1'b0, "psw_abort");
        repeat (20) step();
        PSW_i = 1'b0;
        repeat (30) step();
        chk("psw_quiet", 16'(BUSY_o), 16'd0);
        PSW_i = 1'b1;
        wait_busy(1'b1, "psw_start2");
        RUN_i = 1'b1;
        repeat (3) step();
        chk("run_rise_busy", 16'(BUSY_o), 16'd1);
        PSW_i = 1'b0;
        repeat (30) step();
        PSW_i = 1'b1;
        wait_busy(1'b0, "psw_abort2");
        RUN_i = 1'b0;
        repeat (20) step();
        PSW_i = 1'b0;
        repeat (30) step();

        RUN_i = 1'b1;
        repeat (12) step();
        chk("pre_rst_idx", 16'(IDXs_o), 16'd1);
        chk("pre_rst_out", 16'(BUS_BALANCEs_o), 16'h2A);
        RST_i = 1'b1;
        RUN_i = 1'b0;
        step();
        chk("mid_rst_out", 16'(BUS_BALANCEs_o), 16'h3F);
        chk("mid_rst_busy", 16'(BUSY_o), 16'd0);
        chk("mid_rst_idx", 16'(IDXs_o), 16'd0);
        chk("mid_rst_step", 16'(STEP_o), 16'd0);
        RST_i = 1'b0;
        repeat (3) step();
        chk("after_rst_out", 16'(BUS_BALANCEs_o), 16'h3F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
